// File: rtl/tetris_pkg.sv
// Shared playfield definitions for the Tetris display pipeline.
//   BOARD_W / BOARD_H : playfield size in cells (row 0 is the top row)
//   EMPTY_COLOR       : cell value meaning "no block here"
//   row_t             : one playfield row, BOARD_W cells of 16-bit colour
//   scan_state_t      : line_clear_scanner FSM states
package tetris_pkg;

  localparam int          BOARD_W     = 10;
  localparam int          BOARD_H     = 20;
  localparam logic [15:0] EMPTY_COLOR = 16'h000F;

  typedef logic [BOARD_W-1:0][15:0] row_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT     = 3'd2,
    EVAL     = 3'd3,
    CLEAR    = 3'd4,
    WAIT_ACK = 3'd5,
    DONE     = 3'd6
  } scan_state_t;

endpackage

// File: rtl/line_clear_scanner_if.sv
// Scanner <-> VRAM writer link.
//   Row read : row_ld (1-cycle request) + row, answered by row_ready + read_reg.
//   Row clear: clear_the_row_ho is held with clear_row/clear_num_rows stable
//              until the writer pulses clear_ack; the request drops the
//              cycle after the ack is sampled.
//   master = scanner side, slave = VRAM writer side.
interface line_clear_scanner_if;
  logic              row_ld;
  logic [7:0]        row;
  logic              row_ready;
  tetris_pkg::row_t  read_reg;
  logic              clear_the_row_ho;
  logic [7:0]        clear_row;
  logic [7:0]        clear_num_rows;
  logic              clear_ack;

  modport master (
    output row_ld, row, clear_the_row_ho, clear_row, clear_num_rows,
    input  row_ready, read_reg, clear_ack
  );

  modport slave (
    input  row_ld, row, clear_the_row_ho, clear_row, clear_num_rows,
    output row_ready, read_reg, clear_ack
  );
endinterface

// File: rtl/row_classify.sv
// Combinational row classifier.
//   cells_i : one playfield row
//   full_o  : every cell differs from EMPTY_COLOR
//   empty_o : every cell equals EMPTY_COLOR
module row_classify
  import tetris_pkg::*;
(
  input  row_t cells_i,
  output logic full_o,
  output logic empty_o
);

  always_comb begin
    full_o  = 1'b1;
    empty_o = 1'b1;
    for (int c = 0; c < BOARD_W; c++) begin
      if (cells_i[c] == EMPTY_COLOR) full_o  = 1'b0;
      else                           empty_o = 1'b0;
    end
  end

endmodule

// File: rtl/line_clear_scanner.sv
// Line-clear scanner: after each piece lock, reads the playfield bottom-up,
// finds runs of up to four full rows and asks the VRAM writer to collapse
// them, rescanning from the bottom after each collapse.
//   clk, reset  : clock, asynchronous active-low reset
//   start       : piece-lock strobe (collapsed into one pending scan if busy)
//   vram        : row read / row clear link to the VRAM writer
//   busy        : FSM not in IDLE
//   scan_done   : one-cycle pulse when a scan finds nothing more to clear
//   lines_total : saturating count of cleared lines
//   state_o     : current FSM state (debug)
module line_clear_scanner
  import tetris_pkg::*;
#(
  parameter int RD_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  line_clear_scanner_if.master vram,
  output logic                 busy,
  output logic                 scan_done,
  output logic [15:0]          lines_total,
  output scan_state_t          state_o
);

  localparam int          CW      = $clog2(RD_TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [7:0]  ROW_BOT = 8'(BOARD_H - 1);

  scan_state_t   state_q, state_d;
  logic [7:0]    row_q, row_d;
  logic [7:0]    run_base_q, run_base_d;
  logic [2:0]    run_len_q, run_len_d;
  row_t          cells_q, cells_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          ho_q, ho_d;
  logic [7:0]    clear_row_q, clear_row_d;
  logic [7:0]    clear_num_q, clear_num_d;
  logic [15:0]   lines_q, lines_d;
  logic          pending_q, pending_d;

  logic          full, empty;
  logic [2:0]    run_len_inc;
  logic [16:0]   lines_sum;

  row_classify u_classify (
    .cells_i (cells_q),
    .full_o  (full),
    .empty_o (empty)
  );

  assign run_len_inc = run_len_q + 3'd1;
  assign lines_sum   = {1'b0, lines_q} + 17'(run_len_q);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    run_base_d  = run_base_q;
    run_len_d   = run_len_q;
    cells_d     = cells_q;
    tmo_d       = tmo_q;
    ho_d        = ho_q;
    clear_row_d = clear_row_q;
    clear_num_d = clear_num_q;
    lines_d     = lines_q;
    pending_d   = pending_q;

    if (start && state_q != IDLE) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = REQ;
          row_d     = ROW_BOT;
          run_len_d = 3'd0;
        end
      end
      REQ: begin
        // Loaded with 1 so a silent writer sees the re-read exactly
        // RD_TIMEOUT cycles after the previous row_ld.
        tmo_d   = CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (vram.row_ready) begin
          cells_d = vram.read_reg;
          state_d = EVAL;
        end else if (tmo_q == TO_LAST) begin
          state_d = REQ;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      EVAL: begin
        if (full) begin
          if (run_len_q == 3'd0) run_base_d = row_q;
          run_len_d = run_len_inc;
          if (run_len_inc == 3'd4 || row_q == 8'd0) begin
            state_d = CLEAR;
          end else begin
            row_d   = row_q - 8'd1;
            state_d = REQ;
          end
        end else if (run_len_q != 3'd0) begin
          state_d = CLEAR;
        end else if (empty || row_q == 8'd0) begin
          // Nothing stacks above an empty row, so the scan can stop here.
          state_d = DONE;
        end else begin
          row_d   = row_q - 8'd1;
          state_d = REQ;
        end
      end
      CLEAR: begin
        clear_row_d = run_base_q;
        clear_num_d = {5'd0, run_len_q};
        ho_d        = 1'b1;
        state_d     = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (vram.clear_ack) begin
          lines_d   = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
          ho_d      = 1'b0;
          run_len_d = 3'd0;
          row_d     = ROW_BOT;
          state_d   = REQ;
        end
      end
      DONE: begin
        // A strobe landing in this very cycle also counts as pending.
        if (pending_q || start) begin
          pending_d = 1'b0;
          row_d     = ROW_BOT;
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= 8'd0;
      run_base_q  <= 8'd0;
      run_len_q   <= 3'd0;
      cells_q     <= '0;
      tmo_q       <= '0;
      ho_q        <= 1'b0;
      clear_row_q <= 8'd0;
      clear_num_q <= 8'd0;
      lines_q     <= 16'd0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      run_base_q  <= run_base_d;
      run_len_q   <= run_len_d;
      cells_q     <= cells_d;
      tmo_q       <= tmo_d;
      ho_q        <= ho_d;
      clear_row_q <= clear_row_d;
      clear_num_q <= clear_num_d;
      lines_q     <= lines_d;
      pending_q   <= pending_d;
    end
  end

  assign vram.row_ld           = (state_q == REQ);
  assign vram.row              = row_q;
  assign vram.clear_the_row_ho = ho_q;
  assign vram.clear_row        = clear_row_q;
  assign vram.clear_num_rows   = clear_num_q;
  assign busy                  = (state_q != IDLE);
  assign scan_done             = (state_q == DONE);
  assign lines_total           = lines_q;
  assign state_o               = state_q;

endmodule

// File: tb/tb_line_clear_scanner.sv
module tb_line_clear_scanner;
  import tetris_pkg::*;

  localparam int RD_TIMEOUT = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  line_clear_scanner_if vif ();
  logic        busy, scan_done;
  logic [15:0] lines_total;
  scan_state_t state_o;

  line_clear_scanner #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .vram        (vif.master),
    .busy        (busy),
    .scan_done   (scan_done),
    .lines_total (lines_total),
    .state_o     (state_o)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] board [BOARD_H][BOARD_W];
  logic [15:0] exp_q[$];          // {clear_row, clear_num_rows}
  logic [15:0] exp_lines = 16'd0;
  logic        respond_en = 1'b1;
  logic        ack_en     = 1'b1;
  int          rd_count, done_count;
  logic [7:0]  min_row;
  logic        clear_seen;
  logic        ho_prev = 1'b0;
  logic [7:0]  rsp_row;
  int          rsp_lat;
  logic [15:0] got;
  logic [15:0] exp_v;

  // ---------------- VRAM writer model ----------------
  task automatic collapse(input int base, input int n);
    for (int r = base; r >= 0; r--)
      for (int c = 0; c < BOARD_W; c++)
        board[r][c] = (r - n >= 0) ? board[r-n][c] : EMPTY_COLOR;
  endtask

  always @(negedge clk) begin
    if (reset && vif.row_ld && respond_en) begin
      rsp_row = vif.row;
      rsp_lat = $urandom_range(1, 3);
      repeat (rsp_lat) @(negedge clk);
      for (int c = 0; c < BOARD_W; c++) vif.read_reg[c] = board[rsp_row][c];
      vif.row_ready = 1'b1;
      @(negedge clk);
      vif.row_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset && vif.clear_the_row_ho && ack_en && !vif.clear_ack) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      collapse(int'(vif.clear_row), int'(vif.clear_num_rows));
      vif.clear_ack = 1'b1;
      @(negedge clk);
      vif.clear_ack = 1'b0;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (vif.row_ld) begin
        rd_count++;
        if (!clear_seen && vif.row < min_row) min_row = vif.row;
      end
      if (scan_done) done_count++;
      if (vif.clear_the_row_ho && !ho_prev) begin
        clear_seen = 1'b1;
        got = {vif.clear_row, vif.clear_num_rows};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL clear_cmd: got row=%0d num=%0d, expected no clear", got[15:8], got[7:0]);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            n_fail++;
            $display("FAIL clear_cmd: got row=%0d num=%0d, expected row=%0d num=%0d",
                     got[15:8], got[7:0], exp_v[15:8], exp_v[7:0]);
          end
        end
        n_checks++;
        if (vif.row_ld !== 1'b0) begin
          n_fail++;
          $display("FAIL ld_vs_clear: row_ld=%b with clear request, expected 0", vif.row_ld);
        end
      end
      ho_prev = vif.clear_the_row_ho;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_board();
    for (int r = 0; r < BOARD_H; r++)
      for (int c = 0; c < BOARD_W; c++) board[r][c] = EMPTY_COLOR;
  endtask

  task automatic set_full(input int r);
    for (int c = 0; c < BOARD_W; c++) board[r][c] = 16'h0010 + 16'($urandom_range(0, 200));
  endtask

  task automatic set_partial(input int r);
    for (int c = 0; c < BOARD_W; c++) board[r][c] = (c % 2 == 0) ? 16'h00A0 : EMPTY_COLOR;
  endtask

  task automatic prep();
    rd_count = 0; done_count = 0; min_row = 8'hFF; clear_seen = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, limit);
    end
  endtask

  task automatic end_checks(input string name, input int exp_rd, input int exp_done);
    n_checks++;
    if (lines_total !== exp_lines) begin
      n_fail++; $display("FAIL %s_lines: got %0d expected %0d", name, lines_total, exp_lines);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s_missing_clears: %0d expected clears not seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (done_count != exp_done) begin
      n_fail++; $display("FAIL %s_scan_done: got %0d pulses expected %0d", name, done_count, exp_done);
    end
    if (exp_rd >= 0) begin
      n_checks++;
      if (rd_count != exp_rd) begin
        n_fail++; $display("FAIL %s_reads: got %0d row reads expected %0d", name, rd_count, exp_rd);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0;
    vif.row_ready = 1'b0; vif.clear_ack = 1'b0; vif.read_reg = '0;
    clear_board();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({vif.row_ld, vif.row, vif.clear_the_row_ho, vif.clear_row, vif.clear_num_rows,
         busy, scan_done, lines_total} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ld=%b row=%0d ho=%b crow=%0d cnum=%0d busy=%b done=%b lines=%0d, expected all 0",
               vif.row_ld, vif.row, vif.clear_the_row_ho, vif.clear_row, vif.clear_num_rows,
               busy, scan_done, lines_total);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_o !== IDLE || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: state=%0d busy=%b, expected IDLE/0", state_o, busy);
    end
  endtask

  task automatic test_empty();
    clear_board(); prep();
    pulse_start();
    n_checks++;
    if (vif.row_ld !== 1'b1 || vif.row !== 8'd19) begin
      n_fail++; $display("FAIL empty_first_read: row_ld=%b row=%0d, expected 1/19", vif.row_ld, vif.row);
    end
    wait_idle("empty", 200);
    end_checks("empty", 1, 1);
  endtask

  task automatic test_single();
    clear_board(); prep();
    set_full(19);
    exp_q.push_back({8'd19, 8'd1});
    exp_lines += 16'd1;
    pulse_start();
    wait_idle("single", 500);
    end_checks("single", -1, 1);
  endtask

  task automatic test_four();
    clear_board(); prep();
    for (int r = 16; r <= 19; r++) set_full(r);
    exp_q.push_back({8'd19, 8'd4});
    exp_lines += 16'd4;
    pulse_start();
    wait_idle("four", 500);
    n_checks++;
    if (min_row !== 8'd16) begin
      n_fail++; $display("FAIL four_no_row15_read: lowest row read before clear %0d, expected 16", min_row);
    end
    // first scan reads 19..16, rescan reads 19 only
    end_checks("four", 5, 1);
  endtask

  task automatic test_split();
    clear_board(); prep();
    set_full(19); set_partial(18); set_full(17);
    // After removing row 19 the old row 17 drops into row 18.
    exp_q.push_back({8'd19, 8'd1});
    exp_q.push_back({8'd18, 8'd1});
    exp_lines += 16'd2;
    pulse_start();
    wait_idle("split", 800);
    end_checks("split", -1, 1);
  endtask

  task automatic test_timeout_pending();
    int t0, t1;
    clear_board(); prep();
    respond_en = 1'b0;
    pulse_start();
    t0 = cyc;
    @(negedge clk) start = 1'b1;   // lands while waiting for row_ready
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < RD_TIMEOUT + 50; i++) begin
      @(negedge clk);
      if (i == 100) respond_en = 1'b1;
      if (vif.row_ld) break;
    end
    t1 = cyc;
    n_checks++;
    if (vif.row_ld !== 1'b1 || vif.row !== 8'd19 || (t1 - t0) != RD_TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_reissue: row_ld=%b row=%0d gap=%0d, expected 1/19/%0d",
               vif.row_ld, vif.row, t1 - t0, RD_TIMEOUT);
    end
    wait_idle("pending", 500);
    end_checks("pending", 3, 2);
  endtask

  task automatic test_reset_mid();
    clear_board(); prep();
    set_full(19);
    exp_q.push_back({8'd19, 8'd1});
    ack_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      if (vif.clear_the_row_ho) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (vif.clear_the_row_ho !== 1'b1 || state_o !== WAIT_ACK) begin
      n_fail++; $display("FAIL rstmid_hold: ho=%b state=%0d, expected 1/WAIT_ACK", vif.clear_the_row_ho, state_o);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (vif.clear_the_row_ho !== 1'b0 || busy !== 1'b0 || lines_total !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: ho=%b busy=%b lines=%0d, expected 0/0/0", vif.clear_the_row_ho, busy, lines_total);
    end
    exp_lines = 16'd0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) vif.clear_ack = 1'b1;
    @(negedge clk) vif.clear_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (state_o !== IDLE || busy !== 1'b0 || vif.clear_the_row_ho !== 1'b0 || lines_total !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_late_ack: state=%0d busy=%b ho=%b lines=%0d, expected IDLE/0/0/0",
               state_o, busy, vif.clear_the_row_ho, lines_total);
    end
    ack_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_four();
    test_split();
    test_timeout_pending();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
